instr_encoder: RTL and testbench
================================

# instr_encoder

Instruction encoder and loader: the inverse of the decode-side immediate extraction. It accepts decoded fields (kind, registers, funct3, 12-bit immediate) over a valid/ready handshake, packs them into a 32-bit RV32I word in I/load/S/B format, and writes the words sequentially into instruction memory through a registered write port. It sits between the testbench/boot loader and the instruction memory of the pipelined CPU.

## Interface
- DEPTH, 256: instruction-memory capacity in words.
- BASE_ADDR, 32'h0: byte address of the first written word.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-low.
- start_i  in  1  synchronous restart: clears the word count and the error flag.
- valid_i  in  1  field bundle valid.
- ready_o  out  1  encoder can accept.
- kind_i  in  2  00 ALU-imm (0010011), 01 load (0000011), 10 store (0100011), 11 branch (1100011).
- rd_i, rs1_i, rs2_i  in  5 each  register fields.
- funct3_i  in  3  funct3 field.
- imm_i  in  12  immediate; for branch it is byte offset >> 1.
- mem_we_o  out  1  write strobe, one cycle per word.
- mem_addr_o  out  32  byte address.
- mem_data_o  out  32  encoded instruction.
- count_o  out  $clog2(DEPTH)+1  words written since reset/start.
- full_o  out  1  count_o == DEPTH.
- err_o  out  1  sticky overflow error (see Configuration).

## Operation
- Accept when valid_i && ready_o; ready_o = !full_o && !start_i.
- Packing:
  - ALU-imm/load: {imm[11:0], rs1, funct3, rd, op}.
  - Store: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
  - Branch: {imm[11], imm[9:4], rs2, rs1, funct3, imm[3:0], imm[10], op}.
- Unused fields are ignored: rs2 for kinds 00/01, rd for kinds 10/11.
- Accepted word is registered with address BASE_ADDR + 4*count. The count increments on acceptance and saturates at DEPTH; there is no wrap-around.
- start_i clears count and err_o. It has priority over a same-cycle valid_i, which is not accepted. A write already registered still issues at its original address.

## Timing
- Reset values: ready_o=1, mem_we_o=0, mem_addr_o=0, mem_data_o=0, count_o=0, full_o=0, err_o=0.
- Latency: accept at edge N, then mem_we_o high with addr/data during cycle N+1.
- Throughput: one word per cycle. Back-to-back accepts give consecutive strobes at addresses +4.
- full_o rises in the cycle after the DEPTH-th accept. ready_o falls in the same cycle.
- Reset asserted mid-stream forces all outputs to reset values immediately. A pending write is dropped.

## Configuration
- INSTR_ENCODER_OVF_ERR_EN defined: valid_i high while full_o sets err_o at the next edge. err_o stays set until reset or start_i.
- Undefined: err_o is tied 0 and overflow attempts are silently stalled.

## Structure
- Shared package: opcode constants (OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH) and the 2-bit kind encoding.
- Sub-module imm_pack: combinational field-to-word packer. Top level holds the handshake, count, and write registers.

## Test plan
- addi x1,x0,5 (kind 00, rd 1, rs1 0, f3 0, imm 5) -> mem_data_o=0x00500093 at addr 0x0 one cycle after accept.
- lw x2,8(x1) (kind 01, rd 2, rs1 1, f3 2, imm 8) -> 0x0080A103 at 0x4.
- sw x2,4(x1) (kind 10, rs2 2, rs1 1, f3 2, imm 4) -> 0x0020A223 at 0x8.
- beq x1,x2,-8 (kind 11, rs1 1, rs2 2, f3 0, imm 0xFFC) -> 0xFE208CE3 at 0xC.
- DEPTH=4, five back-to-back valids:
  - four strobes; full_o=1; ready_o=0; fifth held.
  - with the macro, err_o=1 next edge; start_i then clears count and err_o and the fifth writes at 0x0.
- rst_i low in the cycle of mem_we_o -> strobe drops immediately; count_o=0; the next accept writes at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared opcode constants, instruction-kind encoding and the decoded-field bundle
// for the instruction encoder/loader.
package instr_encoder_pkg;

  typedef enum logic [1:0] {
    KIND_ALU_IMM = 2'b00,
    KIND_LOAD    = 2'b01,
    KIND_STORE   = 2'b10,
    KIND_BRANCH  = 2'b11
  } kind_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef struct packed {
    kind_e       kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [11:0] imm;
  } fields_t;

  function automatic logic [6:0] kind_opcode(input kind_e kind);
    case (kind)
      KIND_ALU_IMM: return OP_IMM;
      KIND_LOAD:    return OP_LOAD;
      KIND_STORE:   return OP_STORE;
      default:      return OP_BRANCH;
    endcase
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle handshake, instruction-memory write port and status of the encoder.
// master = boot loader / testbench side, slave = instr_encoder.
interface instr_encoder_if #(
  parameter int DEPTH = 256
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          start_i;
  logic          valid_i;
  logic          ready_o;
  logic [1:0]    kind_i;
  logic [4:0]    rd_i;
  logic [4:0]    rs1_i;
  logic [4:0]    rs2_i;
  logic [2:0]    funct3_i;
  logic [11:0]   imm_i;
  logic          mem_we_o;
  logic [31:0]   mem_addr_o;
  logic [31:0]   mem_data_o;
  logic [CW-1:0] count_o;
  logic          full_o;
  logic          err_o;

  modport master (
    output start_i, valid_i, kind_i, rd_i, rs1_i, rs2_i, funct3_i, imm_i,
    input  ready_o, mem_we_o, mem_addr_o, mem_data_o, count_o, full_o, err_o
  );

  modport slave (
    input  start_i, valid_i, kind_i, rd_i, rs1_i, rs2_i, funct3_i, imm_i,
    output ready_o, mem_we_o, mem_addr_o, mem_data_o, count_o, full_o, err_o
  );

endinterface

// File: rtl/instr_encoder_imm_pack.sv
// Combinational packer: decoded fields -> 32-bit RV32I word (I/load/S/B formats).
module instr_encoder_imm_pack
  import instr_encoder_pkg::*;
(
  input  fields_t     fields,
  output logic [31:0] word
);

  logic [6:0] op;
  assign op = kind_opcode(fields.kind);

  // NOTE: word gets a default first so no path through the case can infer a latch.
  always_comb begin
    word = '0;
    case (fields.kind)
      KIND_STORE:
        word = {fields.imm[11:5], fields.rs2, fields.rs1, fields.funct3, fields.imm[4:0], op};
      // imm holds the byte offset >> 1, so imm[11] is offset bit 12 and imm[10] is bit 11.
      KIND_BRANCH:
        word = {fields.imm[11], fields.imm[9:4], fields.rs2, fields.rs1, fields.funct3,
                fields.imm[3:0], fields.imm[10], op};
      default:
        word = {fields.imm, fields.rs1, fields.funct3, fields.rd, op};
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder/loader: accepts decoded fields, writes packed words sequentially
// into instruction memory. Optional sticky overflow error: INSTR_ENCODER_OVF_ERR_EN.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int          DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  instr_encoder_if.slave  bus
);

  localparam int CW = $clog2(DEPTH) + 1;

  fields_t       fields;
  logic [31:0]   word;
  logic [CW-1:0] count_q;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   data_q;
  logic          full;
  logic          accept;

  assign fields = '{kind:   kind_e'(bus.kind_i),
                    rd:     bus.rd_i,
                    rs1:    bus.rs1_i,
                    rs2:    bus.rs2_i,
                    funct3: bus.funct3_i,
                    imm:    bus.imm_i};

  instr_encoder_imm_pack u_pack (
    .fields (fields),
    .word   (word)
  );

  // Count never passes DEPTH because ready drops once it gets there.
  assign full        = (count_q == CW'(DEPTH));
  assign bus.ready_o = !full && !bus.start_i;
  assign accept      = bus.valid_i && bus.ready_o;

  // NOTE: sequential state uses non-blocking assignments only; every register here is
  // small control/datapath state, so all of it is reset (a pending write is dropped).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      we_q <= accept;
      if (accept) begin
        addr_q <= BASE_ADDR + (32'(count_q) << 2);
        data_q <= word;
      end
      if (bus.start_i)
        count_q <= '0;
      else if (accept)
        count_q <= count_q + CW'(1);
    end
  end

`ifdef INSTR_ENCODER_OVF_ERR_EN
  logic err_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      err_q <= 1'b0;
    else if (bus.start_i)
      err_q <= 1'b0;
    else if (bus.valid_i && full)
      err_q <= 1'b1;
  end

  assign bus.err_o = err_q;
`else
  assign bus.err_o = 1'b0;
`endif

  assign bus.mem_we_o   = we_q;
  assign bus.mem_addr_o = addr_q;
  assign bus.mem_data_o = data_q;
  assign bus.count_o    = count_q;
  assign bus.full_o     = full;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder (DEPTH=4): directed vector table, overflow /
// start / reset sequences, then random traffic against a reference model.
module tb_instr_encoder;

  localparam int D = 4;

  typedef struct {
    logic [1:0]  kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [31:0] exp;
  } vec_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;

  instr_encoder_if #(.DEPTH(D)) bus ();

  instr_encoder #(.DEPTH(D), .BASE_ADDR(32'h0)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input vec_t v, input logic valid, input logic start);
    bus.kind_i   = v.kind;
    bus.rd_i     = v.rd;
    bus.rs1_i    = v.rs1;
    bus.rs2_i    = v.rs2;
    bus.funct3_i = v.f3;
    bus.imm_i    = v.imm;
    bus.valid_i  = valid;
    bus.start_i  = start;
  endtask

  // Reference encoder: branch built from the true byte offset in standard B-type order.
  function automatic logic [31:0] ref_encode(input vec_t v);
    logic [12:0] off;
    off = {v.imm, 1'b0};
    case (v.kind)
      2'd0:    return {v.imm, v.rs1, v.f3, v.rd, 7'h13};
      2'd1:    return {v.imm, v.rs1, v.f3, v.rd, 7'h03};
      2'd2:    return {v.imm[11:5], v.rs2, v.rs1, v.f3, v.imm[4:0], 7'h23};
      default: return {off[12], off[10:5], v.rs2, v.rs1, v.f3, off[4:1], off[11], 7'h63};
    endcase
  endfunction

  task automatic check_idle_reset();
    check("rst_ready", 32'(bus.ready_o), 32'd1);
    check("rst_we",    32'(bus.mem_we_o), 32'd0);
    check("rst_addr",  bus.mem_addr_o, 32'h0);
    check("rst_data",  bus.mem_data_o, 32'h0);
    check("rst_count", 32'(bus.count_o), 32'd0);
    check("rst_full",  32'(bus.full_o), 32'd0);
    check("rst_err",   32'(bus.err_o), 32'd0);
  endtask

  vec_t tbl[5];
  logic exp_err_ovf;

  initial begin
    vec_t v;
    int   cnt;
    logic err;

    tbl[0] = '{kind: 2'd0, rd: 5'd1, rs1: 5'd0, rs2: 5'd9, f3: 3'd0, imm: 12'd5,    exp: 32'h00500093};
    tbl[1] = '{kind: 2'd1, rd: 5'd2, rs1: 5'd1, rs2: 5'd7, f3: 3'd2, imm: 12'd8,    exp: 32'h0080A103};
    tbl[2] = '{kind: 2'd2, rd: 5'd5, rs1: 5'd1, rs2: 5'd2, f3: 3'd2, imm: 12'd4,    exp: 32'h0020A223};
    tbl[3] = '{kind: 2'd3, rd: 5'd3, rs1: 5'd1, rs2: 5'd2, f3: 3'd0, imm: 12'hFFC,  exp: 32'hFE208CE3};
    tbl[4] = '{kind: 2'd0, rd: 5'd3, rs1: 5'd3, rs2: 5'd0, f3: 3'd0, imm: 12'h7FF,  exp: 32'h7FF18193};
`ifdef INSTR_ENCODER_OVF_ERR_EN
    exp_err_ovf = 1'b1;
`else
    exp_err_ovf = 1'b0;
`endif

    drive(tbl[0], 1'b0, 1'b0);
    #2;
    check_idle_reset();
    tick();
    tick();
    rst_i = 1'b1;

    // Test-plan vectors back to back: strobe one cycle after each accept, addresses +4.
    for (int i = 0; i < D; i++) begin
      drive(tbl[i], 1'b1, 1'b0);
      #1;
      check($sformatf("ready_%0d", i), 32'(bus.ready_o), 32'd1);
      tick();
      check($sformatf("we_%0d", i),    32'(bus.mem_we_o), 32'd1);
      check($sformatf("addr_%0d", i),  bus.mem_addr_o, 32'(4 * i));
      check($sformatf("data_%0d", i),  bus.mem_data_o, tbl[i].exp);
      check($sformatf("count_%0d", i), 32'(bus.count_o), 32'(i + 1));
    end
    check("full_after_depth",  32'(bus.full_o), 32'd1);
    check("ready_after_depth", 32'(bus.ready_o), 32'd0);

    // Fifth valid is held while full.
    drive(tbl[4], 1'b1, 1'b0);
    tick();
    check("ovf_we",    32'(bus.mem_we_o), 32'd0);
    check("ovf_count", 32'(bus.count_o), 32'(D));
    check("ovf_err",   32'(bus.err_o), 32'(exp_err_ovf));

    // start wins over the same-cycle valid.
    drive(tbl[4], 1'b1, 1'b1);
    #1;
    check("start_ready", 32'(bus.ready_o), 32'd0);
    tick();
    check("start_we",    32'(bus.mem_we_o), 32'd0);
    check("start_count", 32'(bus.count_o), 32'd0);
    check("start_err",   32'(bus.err_o), 32'd0);
    check("start_full",  32'(bus.full_o), 32'd0);

    drive(tbl[4], 1'b1, 1'b0);
    tick();
    check("fifth_we",   32'(bus.mem_we_o), 32'd1);
    check("fifth_addr", bus.mem_addr_o, 32'h0);
    check("fifth_data", bus.mem_data_o, tbl[4].exp);

    // Reset during the strobe cycle drops the pending write.
    drive(tbl[0], 1'b1, 1'b0);
    tick();
    check("pre_rst_we", 32'(bus.mem_we_o), 32'd1);
    rst_i = 1'b0;
    #1;
    check_idle_reset();
    #1;
    rst_i = 1'b1;
    drive(tbl[1], 1'b1, 1'b0);
    tick();
    check("post_rst_we",   32'(bus.mem_we_o), 32'd1);
    check("post_rst_addr", bus.mem_addr_o, 32'h0);
    check("post_rst_data", bus.mem_data_o, tbl[1].exp);
    drive(tbl[1], 1'b0, 1'b0);
    tick();
    check("post_rst_idle", 32'(bus.mem_we_o), 32'd0);

    // Random traffic against the reference model.
    cnt = 1;
    err = 1'b0;
    for (int n = 0; n < 400; n++) begin
      logic st, vl, exp_ready, exp_acc;
      logic [31:0] exp_addr, exp_data;
      v.kind = 2'($urandom_range(0, 3));
      v.rd   = 5'($urandom);
      v.rs1  = 5'($urandom);
      v.rs2  = 5'($urandom);
      v.f3   = 3'($urandom);
      v.imm  = 12'($urandom);
      v.exp  = '0;
      st = ($urandom_range(0, 99) < 8);
      vl = ($urandom_range(0, 99) < 70);
      drive(v, vl, st);
      exp_ready = (cnt < D) && !st;
      exp_acc   = vl && exp_ready;
      exp_addr  = 32'(cnt * 4);
      exp_data  = ref_encode(v);
      if (st)
        err = 1'b0;
      else if (vl && cnt == D && exp_err_ovf)
        err = 1'b1;
      if (st)
        cnt = 0;
      else if (exp_acc)
        cnt = cnt + 1;
      #1;
      check("rnd_ready", 32'(bus.ready_o), 32'(exp_ready));
      tick();
      check("rnd_we", 32'(bus.mem_we_o), 32'(exp_acc));
      if (exp_acc) begin
        check("rnd_addr", bus.mem_addr_o, exp_addr);
        check("rnd_data", bus.mem_data_o, exp_data);
      end
      check("rnd_count", 32'(bus.count_o), 32'(cnt));
      check("rnd_full",  32'(bus.full_o), 32'(cnt == D));
      check("rnd_err",   32'(bus.err_o), 32'(err));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
